// File: rtl/rvee_pcgen_pkg.sv
// Shared definitions for the RVee PC generator and downstream PC arithmetic.
// Build option: RVEE_PCGEN_MISALIGN_TRAP_EN (see rvee_pcgen.sv).
package rvee_pcgen_pkg;

    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } pcgen_state_t;

    function automatic logic is_insn_aligned(input logic [1:0] pc_lsb);
        return pc_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/rvee_pcgen_if.sv
// PC-issue handshake between the PC generator (master) and the fetch unit (slave).
interface rvee_pcgen_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            jmp_out;
    logic            jmp;
    logic            jmp_ff;
    logic            ready;
    logic            ready_ff;

    modport pcgen_port (
        output valid, pc, jmp_out, jmp, jmp_ff,
        input  ready, ready_ff
    );

    modport fetch_port (
        input  valid, pc, jmp_out, jmp, jmp_ff,
        output ready, ready_ff
    );
endinterface

// File: rtl/rvee_pcgen.sv
// RVee program-counter generator: issues fetch PCs, absorbs redirects, honours stalls.
// Define RVEE_PCGEN_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of masking them.
module rvee_pcgen
    import rvee_pcgen_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    rvee_pcgen_if.pcgen_port     pcgen_if,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    input  logic                 stall,
    output logic                 misalign_valid,
    output logic [XLEN-1:0]      misalign_pc
);

    pcgen_state_t    r_state;
    pcgen_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc_ff;
    logic            r_jmp;
    logic            r_jmp_ff;

    logic            w_live;
    logic            w_redir_ok;
    logic            w_redir_bad;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_valid;
    logic            w_accept;

    // Redirects are ignored while the state register is still in RESET.
    assign w_live = (r_state != ST_RESET);

`ifdef RVEE_PCGEN_MISALIGN_TRAP_EN
    logic            r_mis_valid;
    logic [XLEN-1:0] r_mis_pc;
    logic            w_unused;

    assign w_target    = redirect_pc;
    assign w_redir_ok  = redirect_valid && w_live &&  is_insn_aligned(redirect_pc[1:0]);
    assign w_redir_bad = redirect_valid && w_live && !is_insn_aligned(redirect_pc[1:0]);
    assign w_unused    = pcgen_if.ready_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mis_valid <= 1'b0;
            r_mis_pc    <= '0;
        end else begin
            r_mis_valid <= w_redir_bad;
            if (w_redir_bad) begin
                r_mis_pc <= redirect_pc;
            end
        end
    end

    assign misalign_valid = r_mis_valid;
    assign misalign_pc    = r_mis_pc;
`else
    logic w_unused;

    assign w_target       = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_redir_ok     = redirect_valid && w_live;
    assign w_redir_bad    = 1'b0;
    assign w_unused       = ^{redirect_pc[1:0], pcgen_if.ready_ff};
    assign misalign_valid = 1'b0;
    assign misalign_pc    = '0;
`endif

    // ready never feeds valid, so the handshake is free of combinational loops.
    assign w_valid  = (r_state == ST_RUN) && !stall && !w_redir_bad;
    assign w_pc     = w_redir_ok ? w_target : r_pc_ff;
    assign w_pc_inc = w_pc + XLEN'(INSN_BYTES);
    assign w_accept = w_valid && pcgen_if.ready;

    always_comb begin
        // NOTE: default assigned first so every path drives the next state and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_redir_bad)  w_state_nxt = ST_FAULT;
                else if (stall)   w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_redir_bad)  w_state_nxt = ST_FAULT;
                else if (!stall)  w_state_nxt = ST_RUN;
            end
            ST_FAULT: begin
                if (w_redir_ok)   w_state_nxt = stall ? ST_HOLD : ST_RUN;
            end
            default:              w_state_nxt = ST_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RESET;
            r_pc_ff  <= RESET_PC;
            r_jmp    <= 1'b0;
            r_jmp_ff <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_jmp_ff <= r_jmp;
            if (w_accept) begin
                r_pc_ff <= w_pc_inc;
                r_jmp   <= 1'b0;
            end else if (w_redir_ok) begin
                r_pc_ff <= w_target;
                r_jmp   <= 1'b1;
            end
        end
    end

    assign pcgen_if.valid   = w_valid;
    assign pcgen_if.pc      = w_pc;
    assign pcgen_if.jmp_out = w_redir_ok;
    assign pcgen_if.jmp     = r_jmp;
    assign pcgen_if.jmp_ff  = r_jmp_ff;

endmodule

// File: tb/tb_rvee_pcgen.sv
// Self-checking bench for rvee_pcgen: directed plan steps, then randomized traffic vs a behavioural model.
// Honours RVEE_PCGEN_MISALIGN_TRAP_EN to match the build of the design under test.
module tb_rvee_pcgen;
    import rvee_pcgen_pkg::*;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RVEE_PCGEN_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        misalign_valid;
    logic [31:0] misalign_pc;

    rvee_pcgen_if #(.XLEN(XLEN)) pif ();

    rvee_pcgen #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .pcgen_if       (pif),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .misalign_valid (misalign_valid),
        .misalign_pc    (misalign_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: "booting" is the first cycle after reset, "stalled" means
    // stall was seen last cycle (one bubble after release), "faulted" waits for a good redirect.
    bit          m_known   = 1'b0;
    bit          m_booting;
    bit          m_stalled;
    bit          m_faulted;
    logic [31:0] m_next_pc;
    bit          m_pending;
    bit          m_pending_d;
    bit          m_mis_v;
    logic [31:0] m_mis_pc;

    logic        o_valid;
    logic [31:0] o_pc;
    logic        o_jmp_out;
    logic        o_jmp;
    logic        o_mis_v;
    logic [31:0] o_mis_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    // Apply one cycle of inputs just after a rising edge, check the outputs, advance the model.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit st, input bit rdy, input bit rs);
        bit          ok, bad, e_valid, acc;
        logic [31:0] tgt, e_pc;
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
        pif.ready      = rdy;
        rst            = rs;
        #2;
        ok      = rv && m_known && !m_booting && (!MIS_EN || rpc[1:0] == 2'b00);
        bad     = rv && m_known && !m_booting && MIS_EN && rpc[1:0] != 2'b00;
        tgt     = MIS_EN ? rpc : (rpc & 32'hFFFF_FFFC);
        e_valid = m_known && !m_booting && !m_stalled && !m_faulted && !st && !bad;
        e_pc    = ok ? tgt : m_next_pc;
        acc     = e_valid && rdy;
        o_valid   = pif.valid;
        o_pc      = pif.pc;
        o_jmp_out = pif.jmp_out;
        o_jmp     = pif.jmp;
        o_mis_v   = misalign_valid;
        o_mis_pc  = misalign_pc;
        if (m_known) begin
            check("valid",          {31'b0, pif.valid},     {31'b0, e_valid});
            check("pc",             pif.pc,                 e_pc);
            check("jmp_out",        {31'b0, pif.jmp_out},   {31'b0, ok});
            check("jmp",            {31'b0, pif.jmp},       {31'b0, m_pending});
            check("jmp_ff",         {31'b0, pif.jmp_ff},    {31'b0, m_pending_d});
            check("misalign_valid", {31'b0, misalign_valid}, {31'b0, m_mis_v});
            check("misalign_pc",    misalign_pc,            m_mis_pc);
        end
        @(posedge clk);
        #1;
        if (rs) begin
            m_known     = 1'b1;
            m_booting   = 1'b1;
            m_stalled   = 1'b0;
            m_faulted   = 1'b0;
            m_next_pc   = RESET_PC;
            m_pending   = 1'b0;
            m_pending_d = 1'b0;
            m_mis_v     = 1'b0;
            m_mis_pc    = 32'h0;
        end else if (m_known) begin
            m_pending_d = m_pending;
            if (acc) begin
                m_next_pc = e_pc + 32'd4;
                m_pending = 1'b0;
            end else if (ok) begin
                m_next_pc = tgt;
                m_pending = 1'b1;
            end
            m_mis_v = bad;
            if (bad) m_mis_pc = rpc;
            if (m_booting) begin
                m_booting = 1'b0;
                m_stalled = 1'b0;
            end else if (bad) begin
                m_faulted = 1'b1;
            end else if (m_faulted) begin
                if (ok) begin
                    m_faulted = 1'b0;
                    m_stalled = st;
                end
            end else begin
                m_stalled = st;
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        pif.ready      = 1'b1;
        pif.ready_ff   = 1'b0;
        @(posedge clk);
        #1;
        step(0, 32'h0, 0, 1, 1);
        step(0, 32'h0, 0, 1, 1);

        // Reset release with ready held high.
        step(0, 32'h0, 0, 1, 0);
        check("first_cycle_idle", {31'b0, o_valid}, 32'h0);
        step(0, 32'h0, 0, 1, 0);
        check("first_pc", o_pc, 32'h0);
        check("first_valid", {31'b0, o_valid}, 32'h1);
        step(0, 32'h0, 0, 1, 0);
        check("second_pc", o_pc, 32'h4);

        // Back-pressure at 0x8.
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 0, 0);
            check("hold_pc", o_pc, 32'h8);
            check("hold_valid", {31'b0, o_valid}, 32'h1);
        end
        step(0, 32'h0, 0, 1, 0);
        check("accept_after_hold", o_pc, 32'h8);
        step(0, 32'h0, 0, 1, 0);
        check("after_hold_pc", o_pc, 32'hC);

        // Redirect coincident with accept.
        step(1, 32'h100, 0, 1, 0);
        check("redir_pc", o_pc, 32'h100);
        check("redir_jmp_out", {31'b0, o_jmp_out}, 32'h1);
        step(0, 32'h0, 0, 1, 0);
        check("redir_next_pc", o_pc, 32'h104);
        check("redir_no_jmp", {31'b0, o_jmp}, 32'h0);

        // Redirect under stall.
        step(1, 32'h200, 1, 1, 0);
        check("stall_redir_jmp_out", {31'b0, o_jmp_out}, 32'h1);
        step(0, 32'h0, 1, 1, 0);
        check("stall_jmp_pending", {31'b0, o_jmp}, 32'h1);
        step(0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        check("stall_target_pc", o_pc, 32'h200);
        check("stall_target_valid", {31'b0, o_valid}, 32'h1);
        step(0, 32'h0, 0, 1, 0);
        check("stall_jmp_cleared", {31'b0, o_jmp}, 32'h0);

        // Wrap at the top of the address space.
        step(1, 32'hFFFF_FFFC, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        check("wrap_pc", o_pc, 32'h0);

        // Misaligned redirect target.
        step(1, 32'h102, 0, 1, 0);
`ifdef RVEE_PCGEN_MISALIGN_TRAP_EN
        check("mis_no_issue", {31'b0, o_valid}, 32'h0);
        step(0, 32'h0, 0, 1, 0);
        check("mis_valid", {31'b0, o_mis_v}, 32'h1);
        check("mis_pc", o_mis_pc, 32'h102);
        check("mis_fault_idle", {31'b0, o_valid}, 32'h0);
        step(1, 32'h300, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        check("mis_resume_pc", o_pc, 32'h300);
        check("mis_resume_valid", {31'b0, o_valid}, 32'h1);
`else
        check("mis_masked_pc", o_pc, 32'h100);
        check("mis_masked_valid", {31'b0, o_valid}, 32'h1);
        step(0, 32'h0, 0, 1, 0);
        check("mis_masked_flag", {31'b0, o_mis_v}, 32'h0);
        step(1, 32'h300, 0, 1, 0);
        check("mis_masked_redir", o_pc, 32'h300);
`endif

        // Reset while a jump is pending.
        step(1, 32'h400, 1, 1, 0);
        step(0, 32'h0, 0, 1, 1);
        step(0, 32'h0, 0, 1, 0);
        check("rst_drops_jmp", {31'b0, o_jmp}, 32'h0);
        check("rst_idle", {31'b0, o_valid}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          rv, st, rdy, rs;
            logic [31:0] rpc;
            rs  = ($urandom_range(0, 299) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFFC;
            step(rv, rpc, st, rdy, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
